// File: rtl/lfsr_sram_ctrl_pkg.sv
// lfsr_sram_pkg: shared widths and k-mer hash helpers for lfsr_sram_ctrl.
// fold7/fold8 XOR-fold the k-mer into row address and bit index; step
// advances the row address one LFSR step to pick the bucket-counter row.
package lfsr_sram_pkg;

  localparam int KMER_W = 98;
  localparam int ADDR_W = 7;
  localparam int WORD_W = 64;
  localparam int ROW_W  = 256;
  localparam int LANE_W = 8;
  localparam int IDX_W  = 8;

  localparam logic [ADDR_W-1:0] LFSR_TAPS = 7'b110_0000;

  // Bit j collects every k-mer bit whose index is congruent to j mod 7.
  function automatic logic [ADDR_W-1:0] fold7(input logic [KMER_W-1:0] k);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int i = 0; i < KMER_W; i++) begin
      r[i % ADDR_W] = r[i % ADDR_W] ^ k[i];
    end
    return r;
  endfunction

  // Zero-padding to 104 bits adds nothing to an XOR, so only 98 bits are folded.
  function automatic logic [IDX_W-1:0] fold8(input logic [KMER_W-1:0] k);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < KMER_W; i++) begin
      r[i % IDX_W] = r[i % IDX_W] ^ k[i];
    end
    return r;
  endfunction

  // Fibonacci step for x^7+x^6+1; an all-zero input stays zero.
  function automatic logic [ADDR_W-1:0] step(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-2:0], ^(a & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_sram_ctrl_if.sv
// lfsr_sram_ctrl_if: k-mer input, sequencer strobes and both SRAM bank
// data/address buses. master = sequencer/SRAM side, slave = lfsr_sram_ctrl.
interface lfsr_sram_ctrl_if;
  import lfsr_sram_pkg::*;

  logic [KMER_W-1:0] rg_out;
  logic              EN_LFSR;
  logic              EN_LOAD_SRAM;
  logic [WORD_W-1:0] dataout1, dataout2, dataout3, dataout4;
  logic [WORD_W-1:0] dataout_ba;
  logic              OEB1, CSB1, WEB1;
  logic              OEB2, CSB2, WEB2;
  logic [WORD_W-1:0] datain1, datain2, datain3, datain4;
  logic [WORD_W-1:0] datain_ba;
  logic [ADDR_W-1:0] address;
  logic [ADDR_W-1:0] address_ba;

  modport master (
    output rg_out, EN_LFSR, EN_LOAD_SRAM,
    output dataout1, dataout2, dataout3, dataout4, dataout_ba,
    output OEB1, CSB1, WEB1, OEB2, CSB2, WEB2,
    input  datain1, datain2, datain3, datain4, datain_ba,
    input  address, address_ba
  );

  modport slave (
    input  rg_out, EN_LFSR, EN_LOAD_SRAM,
    input  dataout1, dataout2, dataout3, dataout4, dataout_ba,
    input  OEB1, CSB1, WEB1, OEB2, CSB2, WEB2,
    output datain1, datain2, datain3, datain4, datain_ba,
    output address, address_ba
  );

endinterface

// File: rtl/lfsr_sram_ctrl_hash.sv
// lfsr_sram_hash: combinational k-mer hash -> bitmap row, bucket row, bit index.
module lfsr_sram_hash
  import lfsr_sram_pkg::*;
(
  input  logic [KMER_W-1:0] rg_out,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] addr_ba,
  output logic [IDX_W-1:0]  bitidx
);

  assign addr    = fold7(rg_out);
  assign addr_ba = step(fold7(rg_out));
  assign bitidx  = fold8(rg_out);

endmodule

// File: rtl/lfsr_sram_ctrl.sv
// lfsr_sram_ctrl: registers the k-mer hash and builds SRAM write data for the
// modify half of a read-modify-write (presence bitmap + bucket counters).
// Build option: define LFSR_SRAM_BA_EN to include the bank-2 counter path;
// without it address_ba/datain_ba are tied to zero.
module lfsr_sram_ctrl
  import lfsr_sram_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  lfsr_sram_ctrl_if.slave bus
);

  logic [ADDR_W-1:0] hash_addr_p0;
  logic [ADDR_W-1:0] hash_addr_ba_p0;
  logic [IDX_W-1:0]  hash_bitidx_p0;
  logic [ADDR_W-1:0] address_p1;
  logic [IDX_W-1:0]  bitidx_p1;
  logic [ROW_W-1:0]  row_rd_p1;
  logic [ROW_W-1:0]  row_p2;

  lfsr_sram_hash u_hash (
    .rg_out  (bus.rg_out),
    .addr    (hash_addr_p0),
    .addr_ba (hash_addr_ba_p0),
    .bitidx  (hash_bitidx_p0)
  );

  // ---- stage p0 -> p1: capture hash on EN_LFSR ----
  // Row address and bit index follow the k-mer only when EN_LFSR strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      address_p1 <= '0;
      bitidx_p1  <= '0;
    end else if (bus.EN_LFSR) begin
      address_p1 <= hash_addr_p0;
      bitidx_p1  <= hash_bitidx_p0;
    end
  end

  assign bus.address = address_p1;

  // ---- stage p1 -> p2: bitmap modify on EN_LOAD_SRAM ----
  // A disabled output stage reads as zero, so the row is built from scratch.
  assign row_rd_p1 = bus.OEB1 ? '0
                   : {bus.dataout4, bus.dataout3, bus.dataout2, bus.dataout1};

  // Bitmap write data only moves in a read phase (CSB1 low, WEB1 high), so it
  // stays stable across the sequencer's write cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_p2 <= '0;
    end else if (bus.EN_LOAD_SRAM && !bus.CSB1 && bus.WEB1) begin
      row_p2 <= row_rd_p1 | (ROW_W'(1) << bitidx_p1);
    end
  end

  assign bus.datain1 = row_p2[0*WORD_W +: WORD_W];
  assign bus.datain2 = row_p2[1*WORD_W +: WORD_W];
  assign bus.datain3 = row_p2[2*WORD_W +: WORD_W];
  assign bus.datain4 = row_p2[3*WORD_W +: WORD_W];

`ifdef LFSR_SRAM_BA_EN
  logic [ADDR_W-1:0] address_ba_p1;
  logic [WORD_W-1:0] ba_rd_p1;
  logic [WORD_W-1:0] ba_p2;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [LANE_W-1:0] sat_inc(input logic [LANE_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  // Bump one 8-bit lane of the bucket word, leaving the other lanes alone.
  function automatic logic [WORD_W-1:0] lane_inc(input logic [WORD_W-1:0] w,
                                                 input logic [2:0]        lane);
    logic [WORD_W-1:0] r;
    r = w;
    r[{lane, 3'b000} +: LANE_W] = sat_inc(w[{lane, 3'b000} +: LANE_W]);
    return r;
  endfunction

  // ---- stage p0 -> p1: bucket row ----
  // Bucket row is the hash row advanced one LFSR step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      address_ba_p1 <= '0;
    end else if (bus.EN_LFSR) begin
      address_ba_p1 <= hash_addr_ba_p0;
    end
  end

  assign ba_rd_p1 = bus.OEB2 ? '0 : bus.dataout_ba;

  // ---- stage p1 -> p2: counter modify ----
  // Lane is the top three bits of the bit index; held outside read phases.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ba_p2 <= '0;
    end else if (bus.EN_LOAD_SRAM && !bus.CSB2 && bus.WEB2) begin
      ba_p2 <= lane_inc(ba_rd_p1, bitidx_p1[IDX_W-1 -: 3]);
    end
  end

  assign bus.address_ba = address_ba_p1;
  assign bus.datain_ba  = ba_p2;
`else
  logic unused_ba;
  assign unused_ba      = ^{hash_addr_ba_p0, bus.dataout_ba,
                            bus.OEB2, bus.CSB2, bus.WEB2};
  assign bus.address_ba = '0;
  assign bus.datain_ba  = '0;
`endif

endmodule

// File: tb/tb_lfsr_sram_ctrl.sv
// tb_lfsr_sram_ctrl: directed + small random scoreboard bench for lfsr_sram_ctrl.
// Bank-2 expectations collapse to zero when LFSR_SRAM_BA_EN is not defined.
module tb_lfsr_sram_ctrl;

`ifdef LFSR_SRAM_BA_EN
  localparam bit BA_EN = 1'b1;
`else
  localparam bit BA_EN = 1'b0;
`endif

  typedef struct {
    logic [6:0]   a;
    logic [6:0]   ab;
    logic [255:0] row;
    logic [63:0]  dba;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset;
  exp_t   sb[$];
  int     n_vec = 0;
  int     n_err = 0;

  logic [6:0]   e_a, e_ab;
  logic [255:0] e_row;
  logic [63:0]  e_dba;
  logic [63:0]  r1, r2, r3, rba;
  logic [7:0]   bi, cnt;
  logic [97:0]  rk;

  lfsr_sram_ctrl_if bus();

  lfsr_sram_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] m_fold7(input logic [97:0] k);
    logic [6:0] r;
    for (int j = 0; j < 7; j++) begin
      r[j] = 1'b0;
      for (int i = j; i < 98; i += 7) r[j] = r[j] ^ k[i];
    end
    return r;
  endfunction

  function automatic logic [7:0] m_fold8(input logic [97:0] k);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) begin
      r[j] = 1'b0;
      for (int i = j; i < 98; i += 8) r[j] = r[j] ^ k[i];
    end
    return r;
  endfunction

  function automatic logic [6:0] m_step(input logic [6:0] a);
    return {a[5:0], a[6] ^ a[5]};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp();
    exp_t x;
    x.a   = e_a;
    x.ab  = BA_EN ? e_ab : 7'h0;
    x.row = e_row;
    x.dba = BA_EN ? e_dba : 64'h0;
    sb.push_back(x);
  endtask

  task automatic pop_check(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 256'(1), 256'(0));
    end else begin
      x = sb.pop_front();
      chk({tag, ".address"},    256'(bus.address),    256'(x.a));
      chk({tag, ".address_ba"}, 256'(bus.address_ba), 256'(x.ab));
      chk({tag, ".datain"},     {bus.datain4, bus.datain3, bus.datain2, bus.datain1}, x.row);
      chk({tag, ".datain_ba"},  256'(bus.datain_ba),  256'(x.dba));
    end
  endtask

  task automatic step(input string tag);
    push_exp();
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  task automatic idle_inputs();
    bus.EN_LFSR      = 1'b0;
    bus.EN_LOAD_SRAM = 1'b0;
    bus.OEB1 = 1'b1; bus.CSB1 = 1'b1; bus.WEB1 = 1'b1;
    bus.OEB2 = 1'b1; bus.CSB2 = 1'b1; bus.WEB2 = 1'b1;
  endtask

  task automatic rw_strobes(input logic oeb1, input logic oeb2);
    bus.CSB1 = 1'b0; bus.WEB1 = 1'b1; bus.OEB1 = oeb1;
    bus.CSB2 = 1'b0; bus.WEB2 = 1'b1; bus.OEB2 = oeb2;
  endtask

  task automatic rand_data();
    bus.dataout1   = {$urandom, $urandom};
    bus.dataout2   = {$urandom, $urandom};
    bus.dataout3   = {$urandom, $urandom};
    bus.dataout4   = {$urandom, $urandom};
    bus.dataout_ba = {$urandom, $urandom};
  endtask

  initial begin
    // Reset asserted with live, enabling inputs
    reset = 1'b0;
    bus.rg_out = 98'({$urandom, $urandom, $urandom, $urandom});
    rand_data();
    bus.EN_LFSR = 1'b1; bus.EN_LOAD_SRAM = 1'b1;
    rw_strobes(1'b0, 1'b0);
    e_a = '0; e_ab = '0; e_row = '0; e_dba = '0;
    #3;
    push_exp();
    #1;
    pop_check("rst_async");
    for (int i = 0; i < 3; i++) begin
      bus.rg_out = 98'({$urandom, $urandom, $urandom, $urandom});
      rand_data();
      step("rst_clocked");
    end
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    step("idle1");
    step("idle2");

    // Hash of the reference k-mer
    bus.rg_out  = 98'h0_0002_8002_c000_6c6c_0000_0000;
    bus.EN_LFSR = 1'b1;
    e_a = 7'h07; e_ab = 7'h0E;
    step("hash");
    bus.EN_LFSR = 1'b0;

    // First load: bitmap read disabled, counter read enabled
    bus.EN_LOAD_SRAM = 1'b1;
    rw_strobes(1'b1, 1'b0);
    rand_data();
    bus.dataout_ba = 64'h0;
    e_row = 256'(1) << 64; e_dba = 64'h0000_0000_0001_0000;
    step("load1");

    // Merge into existing read data
    rw_strobes(1'b0, 1'b0);
    bus.dataout1 = 64'h0; bus.dataout2 = 64'h8000_0000_0000_0000;
    bus.dataout3 = 64'h0; bus.dataout4 = 64'h0;
    bus.dataout_ba = 64'h0102_0304_0506_0708;
    e_row = {64'h0, 64'h0, 64'h8000_0000_0000_0001, 64'h0};
    e_dba = 64'h0102_0304_0507_0708;
    step("merge");

    // Lane 2 already at 0xFF
    bus.dataout1 = 64'h1234_5678_9abc_def0; bus.dataout2 = 64'h0;
    bus.dataout_ba = 64'h0000_0000_00FF_0000;
    e_row = {64'h0, 64'h0, 64'h1, 64'h1234_5678_9abc_def0};
    e_dba = 64'h0000_0000_00FF_0000;
    step("sat");

    // Counter read disabled
    rw_strobes(1'b1, 1'b1);
    bus.dataout_ba = '1;
    e_row = 256'(1) << 64; e_dba = 64'h0000_0000_0001_0000;
    step("oeb2");

    // Write phase holds data while a new k-mer is hashed
    rand_data();
    bus.OEB1 = 1'b0; bus.OEB2 = 1'b0; bus.WEB1 = 1'b0; bus.WEB2 = 1'b0;
    bus.EN_LFSR = 1'b1; bus.rg_out = 98'h1;
    e_a = 7'h01; e_ab = 7'h02;
    step("hold_web");

    // Overlap: load uses bitidx 0x01 while hash moves on
    rw_strobes(1'b1, 1'b0);
    bus.dataout_ba = 64'h0;
    bus.rg_out = 98'h40;
    e_a = 7'h40; e_ab = 7'h01;
    e_row = 256'h2; e_dba = 64'h1;
    step("overlap");

    // Next load sees the bitidx captured in the overlap (0x40)
    bus.EN_LFSR = 1'b0;
    e_row = 256'(1) << 64; e_dba = 64'h0000_0000_0001_0000;
    step("new_idx");

    // Chip select high holds both banks
    rand_data();
    bus.CSB1 = 1'b1; bus.CSB2 = 1'b1; bus.OEB1 = 1'b0; bus.OEB2 = 1'b0;
    step("hold_csb");

    // Top bit of the bitmap and top counter lane
    bus.EN_LOAD_SRAM = 1'b0; bus.EN_LFSR = 1'b1; bus.rg_out = 98'hFF;
    e_a = 7'h7E; e_ab = 7'h7C;
    step("hash_top");
    bus.EN_LFSR = 1'b0; bus.EN_LOAD_SRAM = 1'b1;
    rw_strobes(1'b0, 1'b0);
    r1 = {$urandom, $urandom}; r2 = {$urandom, $urandom}; r3 = {$urandom, $urandom};
    bus.dataout1 = r1; bus.dataout2 = r2; bus.dataout3 = r3; bus.dataout4 = 64'h0;
    bus.dataout_ba = 64'hFE00_0000_0000_00AA;
    e_row = {64'h8000_0000_0000_0000, r3, r2, r1};
    e_dba = 64'hFF00_0000_0000_00AA;
    step("top_bit");
    bus.dataout_ba = 64'hFF00_0000_0000_00AA;
    step("top_sat");

    // Random k-mers against the reference model
    for (int n = 0; n < 4; n++) begin
      rk = 98'({$urandom, $urandom, $urandom, $urandom});
      bus.rg_out = rk; bus.EN_LFSR = 1'b1; bus.EN_LOAD_SRAM = 1'b0;
      e_a = m_fold7(rk); e_ab = m_step(e_a);
      step("rand_hash");
      bi = m_fold8(rk);
      rba = {$urandom, $urandom};
      bus.EN_LFSR = 1'b0; bus.EN_LOAD_SRAM = 1'b1;
      rw_strobes(1'b1, 1'b0);
      bus.dataout_ba = rba;
      cnt = rba[bi[7:5]*8 +: 8];
      if (cnt != 8'hFF) cnt = cnt + 8'h1;
      e_dba = rba;
      e_dba[bi[7:5]*8 +: 8] = cnt;
      e_row = 256'(1) << bi;
      step("rand_load");
    end

    // Reset mid-operation clears everything without a clock edge
    #2;
    reset = 1'b0;
    e_a = '0; e_ab = '0; e_row = '0; e_dba = '0;
    push_exp();
    #1;
    pop_check("mid_rst");
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    step("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
